// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the dual-port SoC RAM: independent round-robin
// per port class, 1-cycle tagged read return. Optional macro: RAM_ARB_FWD_EN (write-to-read forwarding).
module ram_arbiter #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_ena,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dia,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_dob
);

  logic          w_m0_wr;
  logic          w_m0_rd;
  logic          w_m1_wr;
  logic          w_m1_rd;
  logic          w_g0_wr;
  logic          w_g1_wr;
  logic          w_g0_rd;
  logic          w_g1_rd;
  logic [DW-1:0] w_rdata;

  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_rd_tag;

  // Class split and per-class round-robin; reset masks every request so grants and enables drop at once.
  always_comb begin
    w_m0_wr = rst_n & m0_req & m0_we;
    w_m0_rd = rst_n & m0_req & ~m0_we;
    w_m1_wr = rst_n & m1_req & m1_we;
    w_m1_rd = rst_n & m1_req & ~m1_we;
    w_g0_wr = w_m0_wr & (~w_m1_wr | ~r_wr_ptr);
    w_g1_wr = w_m1_wr & (~w_m0_wr | r_wr_ptr);
    w_g0_rd = w_m0_rd & (~w_m1_rd | ~r_rd_ptr);
    w_g1_rd = w_m1_rd & (~w_m0_rd | r_rd_ptr);
  end

  always_comb begin
    m0_gnt    = w_g0_wr | w_g0_rd;
    m1_gnt    = w_g1_wr | w_g1_rd;
    ram_ena   = w_g0_wr | w_g1_wr;
    ram_wea   = w_g0_wr | w_g1_wr;
    ram_enb   = w_g0_rd | w_g1_rd;
    ram_addra = '0;
    ram_dia   = '0;
    ram_addrb = '0;
    if (w_g0_wr) begin
      ram_addra = m0_addr;
      ram_dia   = m0_wdata;
    end else if (w_g1_wr) begin
      ram_addra = m1_addr;
      ram_dia   = m1_wdata;
    end
    if (w_g0_rd) begin
      ram_addrb = m0_addr;
    end else if (w_g1_rd) begin
      ram_addrb = m1_addr;
    end
  end

  // Pointers hand priority to the other requester after every grant in their class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_rd_tag <= 2'b00;
    end else begin
      if (w_g0_wr) begin
        r_wr_ptr <= 1'b1;
      end else if (w_g1_wr) begin
        r_wr_ptr <= 1'b0;
      end
      if (w_g0_rd) begin
        r_rd_ptr <= 1'b1;
      end else if (w_g1_rd) begin
        r_rd_ptr <= 1'b0;
      end
      r_rd_tag <= {w_g1_rd, w_g0_rd};
    end
  end

`ifdef RAM_ARB_FWD_EN
  logic          r_fwd_vld;
  logic [DW-1:0] r_fwd_data;

  // Same-cycle write/read to one address: capture write data so the read sees write-first contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_vld  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_vld <= ram_ena & ram_enb & (ram_addra == ram_addrb);
      if (ram_ena & ram_enb & (ram_addra == ram_addrb)) begin
        r_fwd_data <= ram_dia;
      end
    end
  end

  always_comb begin
    w_rdata = r_fwd_vld ? r_fwd_data : ram_dob;
  end
`else
  always_comb begin
    w_rdata = ram_dob;
  end
`endif

  always_comb begin
    m0_rvalid = r_rd_tag[0];
    m1_rvalid = r_rd_tag[1];
    m0_rdata  = r_rd_tag[0] ? w_rdata : '0;
    m1_rdata  = r_rd_tag[1] ? w_rdata : '0;
  end

endmodule
